// File: rtl/vend_controller_if.sv
// Bundle between the vend controller and its user/inventory side.
// The master drives the user strobes and the inventory sold_out flag.
interface vend_controller_if;
  logic       coin_valid;
  logic [6:0] coin_value;
  logic [1:0] item_select;
  logic       buy;
  logic       cancel;
  logic       sold_out;
  logic [1:0] sel_item;
  logic       vend_pulse;
  logic [7:0] credit;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       coin_reject;
  logic       err_soldout;
  logic       err_funds;
  logic       busy;

  modport master (
    output coin_valid, coin_value, item_select, buy, cancel, sold_out,
    input  sel_item, vend_pulse, credit, change_valid, change_amount,
           coin_reject, err_soldout, err_funds, busy
  );

  modport slave (
    input  coin_valid, coin_value, item_select, buy, cancel, sold_out,
    output sel_item, vend_pulse, credit, change_valid, change_amount,
           coin_reject, err_soldout, err_funds, busy
  );
endinterface

// File: rtl/vend_controller.sv
// Coin credit accumulation, purchase check against price and sold-out,
// vend strobe to inventory and change return.
module vend_controller #(
  parameter int unsigned PRICE0     = 75,
  parameter int unsigned PRICE1     = 100,
  parameter int unsigned PRICE2     = 125,
  parameter int unsigned PRICE3     = 150,
  parameter int unsigned MAX_CREDIT = 200
) (
  input logic              clk,
  input logic              rst,
  vend_controller_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StCredit, StCheck, StVend, StChange} state_t;

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [7:0] change_amount_q, change_amount_d;
  logic [1:0] sel_q, sel_d;
  logic       vend_q, vend_d;
  logic       change_valid_q, change_valid_d;
  logic       reject_q, reject_d;
  logic       err_sold_q, err_sold_d;
  logic       err_funds_q, err_funds_d;
  logic       busy;

  logic [7:0] price;
  logic [8:0] coin_sum;
  logic       coin_fits;
  logic       coin_ok;
  logic       can_vend;

  always_comb begin
    unique case (sel_q)
      2'd0: price = 8'(PRICE0);
      2'd1: price = 8'(PRICE1);
      2'd2: price = 8'(PRICE2);
      2'd3: price = 8'(PRICE3);
    endcase
  end

  // 9-bit sum so a large coin on top of high credit cannot wrap past the ceiling.
  assign coin_sum  = {1'b0, credit_q} + {2'b00, bus.coin_value};
  assign coin_fits = (coin_sum <= 9'(MAX_CREDIT));
  assign coin_ok   = bus.coin_valid && coin_fits &&
                     ((state_q == StIdle) ||
                      ((state_q == StCredit) && !bus.cancel && !bus.buy));
  assign can_vend  = !bus.sold_out && (credit_q >= price);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      credit_q        <= '0;
      change_amount_q <= '0;
      sel_q           <= '0;
      vend_q          <= 1'b0;
      change_valid_q  <= 1'b0;
      reject_q        <= 1'b0;
      err_sold_q      <= 1'b0;
      err_funds_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      change_amount_q <= change_amount_d;
      sel_q           <= sel_d;
      vend_q          <= vend_d;
      change_valid_q  <= change_valid_d;
      reject_q        <= reject_d;
      err_sold_q      <= err_sold_d;
      err_funds_q     <= err_funds_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (coin_ok) state_d = StCredit;
      end
      StCredit: begin
        if (bus.cancel)   state_d = StChange;
        else if (bus.buy) state_d = StCheck;
      end
      StCheck:  state_d = can_vend ? StVend : StCredit;
      StVend:   state_d = StChange;
      StChange: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    credit_d        = credit_q;
    sel_d           = sel_q;
    vend_d          = 1'b0;
    err_sold_d      = 1'b0;
    err_funds_d     = 1'b0;
    change_valid_d  = 1'b0;
    change_amount_d = '0;
    reject_d        = bus.coin_valid && !coin_ok;

    if (coin_ok) credit_d = coin_sum[7:0];
    if (state_q inside {StIdle, StCredit}) sel_d = bus.item_select;

    unique case (state_q)
      StCheck: begin
        err_sold_d  = bus.sold_out;
        err_funds_d = !bus.sold_out && (credit_q < price);
        vend_d      = can_vend;
      end
      StVend:   credit_d = credit_q - price;
      StChange: credit_d = '0;
      default: ;
    endcase

    // Change strobe is registered, so it is armed on the way into CHANGE.
    if ((state_d == StChange) && (credit_d != 8'd0)) begin
      change_valid_d  = 1'b1;
      change_amount_d = credit_d;
    end

    busy = state_q inside {StCheck, StVend, StChange};
  end

  assign bus.sel_item      = sel_q;
  assign bus.vend_pulse    = vend_q;
  assign bus.credit        = credit_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change_amount = change_amount_q;
  assign bus.coin_reject   = reject_q;
  assign bus.err_soldout   = err_sold_q;
  assign bus.err_funds     = err_funds_q;
  assign bus.busy          = busy;

endmodule
